// File: rtl/ain_neuron_top.sv
// Two-input neuron: registered ReLU(x1*w1 + x2*w2), saturated to OUT_W signed bits.
// Latency: 1 cycle from inputs to output_val; arithmetic is combinational before the register.
// Backpressure: none; every rising edge with rst high loads a new result.
module ain_neuron_top #(
   parameter int DATA_W = 4,
   parameter int OUT_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] x1,
   input  logic signed [DATA_W-1:0] x2,
   input  logic signed [DATA_W-1:0] w1,
   input  logic signed [DATA_W-1:0] w2,
   output logic signed [OUT_W-1:0]  output_val
);

   // Full-precision product width and the guard-bit sum width.
   localparam int PW = 2 * DATA_W;
   localparam int SW = PW + 1;
   // Comparison width wide enough to hold both the sum and the saturation limit
   // with a spare sign bit, so the limit compare is valid for any OUT_W.
   localparam int CW = ((SW > OUT_W) ? SW : OUT_W) + 1;
   localparam logic signed [CW-1:0] W_MAX_C = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] W_MAX_O = {1'b0, {(OUT_W-1){1'b1}}};

   logic signed [PW-1:0]    w_prod1;
   logic signed [PW-1:0]    w_prod2;
   logic signed [SW-1:0]    w_sum;
   logic signed [CW-1:0]    w_sum_ext;
   logic signed [OUT_W-1:0] w_act;
   logic signed [OUT_W-1:0] r_out;

   // Operands are sign-extended to product width first so the multiply is
   // exact regardless of expression-sizing rules.
   assign w_prod1 = $signed({{DATA_W{x1[DATA_W-1]}}, x1}) * $signed({{DATA_W{w1[DATA_W-1]}}, w1});
   assign w_prod2 = $signed({{DATA_W{x2[DATA_W-1]}}, x2}) * $signed({{DATA_W{w2[DATA_W-1]}}, w2});

   // One extra bit makes the add overflow-free.
   assign w_sum     = $signed({w_prod1[PW-1], w_prod1}) + $signed({w_prod2[PW-1], w_prod2});
   assign w_sum_ext = $signed({{(CW-SW){w_sum[SW-1]}}, w_sum});

   // ReLU followed by clamp to the largest positive OUT_W value.
   always_comb begin
      w_act = '0;
      if (w_sum_ext <= 0) begin
         w_act = '0;
      end else if (w_sum_ext > W_MAX_C) begin
         w_act = W_MAX_O;
      end else begin
         w_act = w_sum_ext[OUT_W-1:0];
      end
   end

   // Output register; reset clears it immediately, independent of the clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_act;
      end
   end

   assign output_val = r_out;

endmodule

// File: tb/tb_ain_neuron_top.sv
// Bench for ain_neuron_top: table vectors, reset/timing sequences, random vs. arithmetic model.
// Latency checked as one edge from input to output.
// Backpressure: none in the design; inputs are driven every cycle.
module tb_ain_neuron_top;

   localparam int DATA_W = 4;
   localparam int OUT_W  = 5;

   logic                     clk;
   logic                     rst;
   logic signed [DATA_W-1:0] x1, x2, w1, w2;
   logic signed [OUT_W-1:0]  output_val;

   int n_checks;
   int n_pass;

   typedef struct {
      logic signed [DATA_W-1:0] x1;
      logic signed [DATA_W-1:0] w1;
      logic signed [DATA_W-1:0] x2;
      logic signed [DATA_W-1:0] w2;
      int                       exp;
      string                    name;
   } vec_t;

   vec_t tbl[8];

   ain_neuron_top #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .x1        (x1),
      .x2        (x2),
      .w1        (w1),
      .w2        (w2),
      .output_val(output_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   // Reference: plain integer arithmetic, ReLU, clamp to 2^(OUT_W-1)-1.
   function automatic int model(int a, int b, int c, int d);
      int s;
      int lim;
      lim = (1 << (OUT_W - 1)) - 1;
      s = a * b + c * d;
      if (s <= 0) return 0;
      if (s > lim) return lim;
      return s;
   endfunction

   function automatic vec_t mk(int a, int b, int c, int d, int e, string n);
      vec_t v;
      v.x1 = DATA_W'(a);
      v.w1 = DATA_W'(b);
      v.x2 = DATA_W'(c);
      v.w2 = DATA_W'(d);
      v.exp = e;
      v.name = n;
      return v;
   endfunction

   task automatic chk(string name, int exp);
      int act;
      act = int'(output_val);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: act=%0d req=%0d at %0t", name, act, exp, $time);
   endtask

   task automatic drive(vec_t v);
      x1 = v.x1; w1 = v.w1; x2 = v.x2; w2 = v.w2;
   endtask

   // Drive at the falling edge, check just after the next rising edge.
   task automatic apply(vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      chk(v.name, v.exp);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;

      tbl[0] = mk( 2,  1,  3,  2,  8, "basic_8");
      tbl[1] = mk( 1,  1,  3, -1,  0, "neg_sum");
      tbl[2] = mk( 1,  1,  1, -1,  0, "zero_sum");
      tbl[3] = mk( 7,  7,  7,  7, 15, "sat_98");
      tbl[4] = mk(-8, -8, -8, -8, 15, "sat_128_nowrap");
      tbl[5] = mk(-8,  7, -8,  7,  0, "neg_112");
      tbl[6] = mk( 5,  1,  0,  0,  5, "plain_5");
      tbl[7] = mk( 3,  5,  0,  0, 15, "sat_edge_15");

      // Reset held low: output 0 regardless of inputs and edges.
      rst = 1'b0;
      x1 = '0; x2 = '0; w1 = '0; w2 = '0;
      #3;
      chk("reset_state", 0);
      repeat (3) begin
         @(negedge clk);
         drive(tbl[3]);
         @(posedge clk);
         #1;
         chk("reset_hold", 0);
      end
      // Release between edges: still 0 until the first edge with rst high.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("release_no_edge", 0);
      @(posedge clk);
      #1;
      chk("release_first_edge", 15);

      // Table vectors on consecutive edges (each held exactly one cycle).
      for (int i = 0; i < 8; i++) apply(tbl[i]);

      // Back-to-back 8, 0, 15, 5 with explicit 1-cycle lag.
      apply(tbl[0]);
      apply(tbl[1]);
      apply(tbl[3]);
      apply(tbl[6]);

      // Input change between edges does not disturb the registered output.
      apply(tbl[0]);
      drive(tbl[4]);
      #2;
      chk("mid_cycle_input_ignored", 8);
      @(posedge clk);
      #1;
      chk("next_edge_takes_new", 15);

      // Asynchronous reset while output is 8.
      apply(tbl[0]);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_immediate", 0);
      @(posedge clk);
      #1;
      chk("async_reset_hold", 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_release_no_edge", 0);
      @(posedge clk);
      #1;
      chk("async_release_edge", 8);

      // Random vectors against the arithmetic model.
      for (int i = 0; i < 300; i++) begin
         vec_t v;
         v.x1 = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         v.w1 = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         v.x2 = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         v.w2 = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         v.exp = model(int'(v.x1), int'(v.w1), int'(v.x2), int'(v.w2));
         v.name = "random";
         apply(v);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
